// File: rtl/sprite_line_scheduler_if.sv
// Bus bundle between the sprite line scheduler and its host / renderers.
// The scheduler itself takes the slave modport; the VGA timing, host config
// and renderer side takes the master modport.
interface sprite_line_scheduler_if #(
    parameter int NUM_SPRITES = 8,
    parameter int SLOTS       = 4
);
    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [9:0]          h_count;
    logic [9:0]          v_count;
    logic                cfg_we;
    logic [IW-1:0]       cfg_idx;
    logic [9:0]          cfg_x;
    logic [9:0]          cfg_y;
    logic                cfg_en;
    logic                ovf_clr;
    logic [SLOTS-1:0]    slot_visible;
    logic [SLOTS-1:0]    slot_valid;
    logic [10*SLOTS-1:0] slot_x;
    logic [10*SLOTS-1:0] slot_y;
    logic [IW*SLOTS-1:0] slot_id;
    logic                pix_valid;
    logic [SW-1:0]       pix_slot;
    logic                overflow;
    logic                busy;

    modport master (
        output h_count, v_count, cfg_we, cfg_idx, cfg_x, cfg_y, cfg_en,
               ovf_clr, slot_visible,
        input  slot_valid, slot_x, slot_y, slot_id, pix_valid, pix_slot,
               overflow, busy
    );

    modport slave (
        input  h_count, v_count, cfg_we, cfg_idx, cfg_x, cfg_y, cfg_en,
               ovf_clr, slot_visible,
        output slot_valid, slot_x, slot_y, slot_id, pix_valid, pix_slot,
               overflow, busy
    );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the descriptor table during horizontal
// blank, loads up to SLOTS intersecting sprites for the next line, and
// arbitrates renderer visible flags into one registered winning slot.
//
// state  | meaning
// IDLE   | waiting for the start of horizontal blank
// SCAN   | testing one descriptor per clock, filling the shadow slots
// COMMIT | shadow slots copied to the active slot outputs
module sprite_line_scheduler #(
    parameter int NUM_SPRITES = 8,
    parameter int SLOTS       = 4,
    parameter int SPR_H       = 4,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525
) (
    input logic                FPGA_Clock,
    input logic                reset,
    sprite_line_scheduler_if.slave bus
);
    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CW = $clog2(SLOTS + 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t              state;
    logic                d_en [NUM_SPRITES];
    logic [9:0]          d_x  [NUM_SPRITES];
    logic [9:0]          d_y  [NUM_SPRITES];
    logic [9:0]          prev_h;
    logic [9:0]          tgt;
    logic [IW-1:0]       idx;
    logic [CW-1:0]       cnt;
    logic                sh_valid [SLOTS];
    logic [9:0]          sh_x     [SLOTS];
    logic [9:0]          sh_y     [SLOTS];
    logic [IW-1:0]       sh_id    [SLOTS];
    logic [SLOTS-1:0]    act_valid;
    logic [10*SLOTS-1:0] act_x;
    logic [10*SLOTS-1:0] act_y;
    logic [IW*SLOTS-1:0] act_id;
    logic                busy_r;
    logic                ovf_r;
    logic                pix_valid_r;
    logic [SW-1:0]       pix_slot_r;
    logic                hb_start;
    logic [9:0]          tgt_next;
    logic                hit;
    logic                win_valid;
    logic [SW-1:0]       win_slot;

    assign hb_start = (bus.h_count == 10'(H_ACTIVE)) && (prev_h != 10'(H_ACTIVE));
    assign tgt_next = (bus.v_count == 10'(V_TOTAL - 1)) ? 10'd0 : bus.v_count + 10'd1;
    // 11-bit compare so a sprite near the bottom of the y range never wraps onto line 0
    assign hit = d_en[idx] && ({1'b0, d_y[idx]} <= {1'b0, tgt})
                 && ({1'b0, tgt} < {1'b0, d_y[idx]} + 11'(SPR_H));

    // Host descriptor writes, accepted in every state.
    always_ff @(posedge FPGA_Clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                d_en[i] <= 1'b0;
                d_x[i]  <= 10'd0;
                d_y[i]  <= 10'd0;
            end
        end else if (bus.cfg_we) begin
            d_en[bus.cfg_idx] <= bus.cfg_en;
            d_x[bus.cfg_idx]  <= bus.cfg_x;
            d_y[bus.cfg_idx]  <= bus.cfg_y;
        end
    end

    // Previous h_count for blank-start edge detection.
    always_ff @(posedge FPGA_Clock or posedge reset) begin
        if (reset) prev_h <= 10'd0;
        else       prev_h <= bus.h_count;
    end

    // Scan FSM with shadow/active slot sets, busy and sticky overflow.
    always_ff @(posedge FPGA_Clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tgt       <= 10'd0;
            idx       <= '0;
            cnt       <= '0;
            busy_r    <= 1'b0;
            ovf_r     <= 1'b0;
            act_valid <= '0;
            act_x     <= '0;
            act_y     <= '0;
            act_id    <= '0;
            for (int k = 0; k < SLOTS; k++) begin
                sh_valid[k] <= 1'b0;
                sh_x[k]     <= 10'd0;
                sh_y[k]     <= 10'd0;
                sh_id[k]    <= '0;
            end
        end else begin
            // clear first so a same-cycle set below takes precedence
            if (bus.ovf_clr) ovf_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (hb_start) begin
                        tgt    <= tgt_next;
                        idx    <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= SCAN;
                        for (int k = 0; k < SLOTS; k++) begin
                            sh_valid[k] <= 1'b0;
                            sh_x[k]     <= 10'd0;
                            sh_y[k]     <= 10'd0;
                            sh_id[k]    <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (hit) begin
                        if (cnt < CW'(SLOTS)) begin
                            for (int k = 0; k < SLOTS; k++) begin
                                if (cnt == CW'(k)) begin
                                    sh_valid[k] <= 1'b1;
                                    sh_x[k]     <= d_x[idx];
                                    sh_y[k]     <= d_y[idx];
                                    sh_id[k]    <= idx;
                                end
                            end
                            cnt <= cnt + CW'(1);
                        end else begin
                            ovf_r <= 1'b1;
                        end
                    end
                    if (idx == IW'(NUM_SPRITES - 1)) state <= COMMIT;
                    else                             idx   <= idx + IW'(1);
                end
                COMMIT: begin
                    for (int k = 0; k < SLOTS; k++) begin
                        act_valid[k]          <= sh_valid[k];
                        act_x[10*k +: 10]     <= sh_x[k];
                        act_y[10*k +: 10]     <= sh_y[k];
                        act_id[IW*k +: IW]    <= sh_id[k];
                    end
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lowest-index visible valid slot wins.
    always_comb begin
        win_valid = 1'b0;
        win_slot  = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (bus.slot_visible[k] && act_valid[k]) begin
                win_valid = 1'b1;
                win_slot  = SW'(k);
            end
        end
    end

    // Registered arbitration result for the colour stage.
    always_ff @(posedge FPGA_Clock or posedge reset) begin
        if (reset) begin
            pix_valid_r <= 1'b0;
            pix_slot_r  <= '0;
        end else begin
            pix_valid_r <= win_valid;
            pix_slot_r  <= win_slot;
        end
    end

    assign bus.slot_valid = act_valid;
    assign bus.slot_x     = act_x;
    assign bus.slot_y     = act_y;
    assign bus.slot_id    = act_id;
    assign bus.pix_valid  = pix_valid_r;
    assign bus.pix_slot   = pix_slot_r;
    assign bus.overflow   = ovf_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler with a table-level reference model.
module tb_sprite_line_scheduler;
    localparam int NS = 8;
    localparam int SL = 4;
    localparam int IW = 3;
    localparam int SPR_H = 4;
    localparam int H_ACTIVE = 640;
    localparam int V_TOTAL = 525;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sprite_line_scheduler_if #(.NUM_SPRITES(NS), .SLOTS(SL)) bus ();

    sprite_line_scheduler #(
        .NUM_SPRITES(NS), .SLOTS(SL), .SPR_H(SPR_H),
        .H_ACTIVE(H_ACTIVE), .V_TOTAL(V_TOTAL)
    ) dut (
        .FPGA_Clock(clk),
        .reset(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int m_en [NS];
    int m_x  [NS];
    int m_y  [NS];
    int s_en [NS];
    int s_x  [NS];
    int s_y  [NS];
    bit m_ovf;
    logic [SL-1:0] cur_valid;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int i, input int x, input int y, input int en);
        bus.cfg_we  = 1'b1;
        bus.cfg_idx = IW'(i);
        bus.cfg_x   = 10'(x);
        bus.cfg_y   = 10'(y);
        bus.cfg_en  = 1'(en);
        tick();
        bus.cfg_we  = 1'b0;
        m_en[i] = en;
        m_x[i]  = x;
        m_y[i]  = y;
    endtask

    task automatic clear_table();
        for (int i = 0; i < NS; i++) cfg_write(i, 0, 0, 0);
    endtask

    task automatic pulse_ovf_clr(input string name);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        m_ovf = 1'b0;
        n_cmp++;
        if (bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL %s overflow_after_clr: got %b want 0", name, bus.overflow);
        end
    endtask

    // One blanking interval on line v. When wcyc>=1, descriptor widx gets en=wen
    // written on the wcyc-th clock after blank start (that clock scans idx wcyc-1).
    task automatic run_line(input string name, input int v, input int wcyc,
                            input int widx, input int wen);
        int tgt;
        int n_busy;
        int j;
        int hits[$];
        logic [SL-1:0]    ev;
        logic [10*SL-1:0] ex;
        logic [10*SL-1:0] ey;
        logic [IW*SL-1:0] eid;
        tgt = (v == V_TOTAL - 1) ? 0 : v + 1;
        for (int i = 0; i < NS; i++) begin
            s_en[i] = m_en[i];
            s_x[i]  = m_x[i];
            s_y[i]  = m_y[i];
            if (wcyc >= 1 && i == widx && i >= wcyc) s_en[i] = wen;
        end
        bus.v_count = 10'(v);
        bus.h_count = 10'(H_ACTIVE);
        tick();
        bus.h_count = 10'(H_ACTIVE + 1);
        n_busy = bus.busy ? 1 : 0;
        j = 1;
        while (bus.busy && j < 40) begin
            if (j == wcyc) begin
                bus.cfg_we  = 1'b1;
                bus.cfg_idx = IW'(widx);
                bus.cfg_x   = 10'(m_x[widx]);
                bus.cfg_y   = 10'(m_y[widx]);
                bus.cfg_en  = 1'(wen);
            end
            tick();
            bus.cfg_we = 1'b0;
            if (bus.busy) n_busy++;
            j++;
        end
        if (wcyc >= 1) m_en[widx] = wen;
        for (int i = 0; i < NS; i++)
            if (s_en[i] != 0 && s_y[i] <= tgt && tgt < s_y[i] + SPR_H) hits.push_back(i);
        ev = '0; ex = '0; ey = '0; eid = '0;
        for (int k = 0; k < SL && k < hits.size(); k++) begin
            ev[k]            = 1'b1;
            ex[10*k +: 10]   = 10'(s_x[hits[k]]);
            ey[10*k +: 10]   = 10'(s_y[hits[k]]);
            eid[IW*k +: IW]  = IW'(hits[k]);
        end
        if (hits.size() > SL) m_ovf = 1'b1;
        cur_valid = ev;
        n_cmp++;
        if (n_busy != NS + 1) begin
            n_err++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, n_busy, NS + 1);
        end
        n_cmp++;
        if (bus.slot_valid !== ev) begin
            n_err++;
            $display("FAIL %s slot_valid: got %b want %b", name, bus.slot_valid, ev);
        end
        n_cmp++;
        if (bus.slot_x !== ex) begin
            n_err++;
            $display("FAIL %s slot_x: got %h want %h", name, bus.slot_x, ex);
        end
        n_cmp++;
        if (bus.slot_y !== ey) begin
            n_err++;
            $display("FAIL %s slot_y: got %h want %h", name, bus.slot_y, ey);
        end
        n_cmp++;
        if (bus.slot_id !== eid) begin
            n_err++;
            $display("FAIL %s slot_id: got %h want %h", name, bus.slot_id, eid);
        end
        n_cmp++;
        if (bus.overflow !== m_ovf) begin
            n_err++;
            $display("FAIL %s overflow: got %b want %b", name, bus.overflow, m_ovf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus.busy, bus.overflow, bus.pix_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL reset flags: got %b want 000", {bus.busy, bus.overflow, bus.pix_valid});
        end
        n_cmp++;
        if ({bus.slot_valid, bus.slot_x, bus.slot_y, bus.slot_id, bus.pix_slot} !== '0) begin
            n_err++;
            $display("FAIL reset slots: got nonzero slot/pix_slot outputs");
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < NS; i++) begin m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; end
        m_ovf = 1'b0;
        cur_valid = '0;
    endtask

    task automatic test_two_sprites();
        cfg_write(2, 100, 50, 1);
        cfg_write(5, 300, 52, 1);
        run_line("two_sprites", 51, 0, 0, 0);
        n_cmp++;
        if (bus.slot_valid !== 4'b0011) begin
            n_err++;
            $display("FAIL two_sprites literal_valid: got %b want 0011", bus.slot_valid);
        end
    endtask

    task automatic test_overflow();
        clear_table();
        for (int i = 0; i < 6; i++) cfg_write(i, 10 * i + 5, 10, 1);
        run_line("overflow", 9, 0, 0, 0);
        n_cmp++;
        if (bus.overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow literal: got %b want 1", bus.overflow);
        end
        pulse_ovf_clr("overflow");
    endtask

    task automatic test_boundaries();
        int vs [4] = '{19, 22, 18, 23};
        bit hs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        clear_table();
        cfg_write(0, 7, 20, 1);
        for (int t = 0; t < 4; t++) begin
            run_line("boundary_y20", vs[t], 0, 0, 0);
            n_cmp++;
            if (bus.slot_valid[0] !== hs[t]) begin
                n_err++;
                $display("FAIL boundary_y20 line%0d hit: got %b want %b", vs[t] + 1, bus.slot_valid[0], hs[t]);
            end
        end
        cfg_write(0, 7, 0, 1);
        run_line("wrap_y0", V_TOTAL - 1, 0, 0, 0);
        n_cmp++;
        if (bus.slot_valid[0] !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_y0 hit: got %b want 1", bus.slot_valid[0]);
        end
        cfg_write(0, 7, 1022, 1);
        run_line("y1022_line0", V_TOTAL - 1, 0, 0, 0);
        n_cmp++;
        if (bus.slot_valid[0] !== 1'b0) begin
            n_err++;
            $display("FAIL y1022_line0 hit: got %b want 0", bus.slot_valid[0]);
        end
    endtask

    task automatic test_arbitration();
        logic [SL-1:0] vis;
        logic [SL-1:0] m;
        logic          epv;
        int            eps;
        clear_table();
        for (int i = 0; i < 3; i++) cfg_write(i, 50 + i, 40, 1);
        run_line("arb_setup", 40, 0, 0, 0);
        for (int t = 0; t < 14; t++) begin
            if (t == 0)      vis = 4'b0110;
            else if (t == 1) vis = 4'b1000;
            else             vis = SL'($urandom_range(0, 15));
            bus.slot_visible = vis;
            tick();
            m = vis & cur_valid;
            epv = (m != 0);
            eps = 0;
            for (int k = SL - 1; k >= 0; k--) if (m[k]) eps = k;
            n_cmp++;
            if (bus.pix_valid !== epv) begin
                n_err++;
                $display("FAIL arb pix_valid vis=%b: got %b want %b", vis, bus.pix_valid, epv);
            end
            n_cmp++;
            if (int'(bus.pix_slot) != eps) begin
                n_err++;
                $display("FAIL arb pix_slot vis=%b: got %0d want %0d", vis, bus.pix_slot, eps);
            end
        end
        bus.slot_visible = '0;
        tick();
    endtask

    task automatic test_hold();
        int hold [2] = '{3, 15};
        int rises;
        logic pb;
        for (int t = 0; t < 2; t++) begin
            bus.h_count = 10'(H_ACTIVE + 1);
            tick();
            rises = 0;
            pb = bus.busy;
            bus.h_count = 10'(H_ACTIVE);
            for (int c = 0; c < hold[t]; c++) begin
                tick();
                if (bus.busy && !pb) rises++;
                pb = bus.busy;
            end
            bus.h_count = 10'(H_ACTIVE + 1);
            for (int c = 0; c < 20; c++) begin
                tick();
                if (bus.busy && !pb) rises++;
                pb = bus.busy;
            end
            n_cmp++;
            if (rises != 1) begin
                n_err++;
                $display("FAIL hold%0d scans: got %0d want 1", hold[t], rises);
            end
        end
    endtask

    task automatic test_mid_write();
        clear_table();
        cfg_write(1, 11, 100, 1);
        cfg_write(6, 66, 100, 1);
        run_line("mid_write_c3", 99, 3, 6, 0);
        n_cmp++;
        if (bus.slot_valid !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_write_c3 excluded: got %b want 0001", bus.slot_valid);
        end
        cfg_write(6, 66, 100, 1);
        run_line("mid_write_c7", 99, 7, 6, 0);
        cfg_write(6, 66, 100, 1);
        run_line("mid_write_c8", 99, 8, 6, 0);
        n_cmp++;
        if (bus.slot_valid !== 4'b0011) begin
            n_err++;
            $display("FAIL mid_write_c8 included: got %b want 0011", bus.slot_valid);
        end
    endtask

    task automatic test_reset_mid_scan();
        clear_table();
        for (int i = 0; i < 6; i++) cfg_write(i, i, 10, 1);
        run_line("pre_reset", 9, 0, 0, 0);
        bus.slot_visible = 4'hF;
        tick();
        n_cmp++;
        if (bus.pix_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset pix_valid: got %b want 1", bus.pix_valid);
        end
        bus.h_count = 10'(H_ACTIVE);
        bus.v_count = 10'd9;
        tick();
        tick();
        tick();
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_scan busy: got %b want 1", bus.busy);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.slot_valid, bus.overflow, bus.pix_valid} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_mid_scan outputs: got %b want 0000000",
                     {bus.busy, bus.slot_valid, bus.overflow, bus.pix_valid});
        end
        for (int i = 0; i < NS; i++) begin m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; end
        m_ovf = 1'b0;
        cur_valid = '0;
        tick();
        rst = 1'b0;
        bus.h_count = 10'(H_ACTIVE + 1);
        bus.slot_visible = '0;
        tick();
        cfg_write(3, 33, 10, 1);
        run_line("after_reset", 9, 0, 0, 0);
    endtask

    task automatic test_random();
        int r;
        for (int line = 0; line < 8; line++) begin
            for (int i = 0; i < NS; i++) begin
                r = $urandom_range(0, 9);
                cfg_write(i, $urandom_range(0, 1023),
                          (r == 0) ? $urandom_range(1020, 1023) : $urandom_range(0, 30),
                          (r < 7) ? 1 : 0);
            end
            if ($urandom_range(0, 2) == 0) pulse_ovf_clr("random");
            run_line("random", ($urandom_range(0, 9) == 0) ? V_TOTAL - 1 : $urandom_range(0, 30),
                     $urandom_range(0, 8), $urandom_range(0, NS - 1), $urandom_range(0, 1));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.h_count = '0;
        bus.v_count = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_x = '0;
        bus.cfg_y = '0;
        bus.cfg_en = 1'b0;
        bus.ovf_clr = 1'b0;
        bus.slot_visible = '0;
        test_reset();
        test_two_sprites();
        test_overflow();
        test_boundaries();
        test_arbitration();
        test_hold();
        test_mid_write();
        test_reset_mid_scan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sprite scheduler for the VGA sprite pipeline.
- Holds a table of NUM_SPRITES sprite descriptors (position, enable) written by the host.
- During each horizontal blank, scans the table and loads up to SLOTS sprites that intersect the next visible line into slot registers. These slots drive the per-sprite renderers.
- During active video, arbitrates the renderers' visible flags into one registered, priority-selected slot index for the colour stage.

Parameters:
- NUM_SPRITES, 8, descriptor table entries (power of 2).
- SLOTS, 4, sprites renderable per line.
- SPR_H, 4, sprite height in lines.
- H_ACTIVE, 640, first h_count value of horizontal blank.
- V_TOTAL, 525, lines per frame; v_count wraps at V_TOTAL-1.

Ports:
- FPGA_Clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- h_count  in  10  current pixel column from VGA timing.
- v_count  in  10  current line from VGA timing.
- cfg_we  in  1  descriptor write strobe.
- cfg_idx  in  log2(NUM_SPRITES)  descriptor index.
- cfg_x  in  10  sprite x_pos.
- cfg_y  in  10  sprite y_pos.
- cfg_en  in  1  sprite enable.
- ovf_clr  in  1  clears overflow flag.
- slot_visible  in  SLOTS  per-slot visible flags from the renderers.
- slot_valid  out  SLOTS  slot holds a sprite for the current line.
- slot_x  out  10*SLOTS  x_pos per slot, slot k at bits [10k+9:10k].
- slot_y  out  10*SLOTS  y_pos per slot, same packing.
- slot_id  out  log2(NUM_SPRITES)*SLOTS  descriptor index per slot.
- pix_valid  out  1  some valid slot is visible at the current pixel.
- pix_slot  out  log2(SLOTS)  winning slot.
- overflow  out  1  sticky: a line needed more than SLOTS sprites.
- busy  out  1  scan in progress.

Behaviour:
- Reset (async) clears:
  - all descriptors: en=0, x=0, y=0;
  - all slot outputs, both active and shadow sets;
  - pix_valid=0, pix_slot=0, overflow=0, busy=0;
  - state=IDLE.
- Descriptor write: when cfg_we=1, the entry at cfg_idx is updated on the clock edge. Writes are accepted in every state.
- Trigger: hb_start is a 1-cycle pulse on the clock where h_count==H_ACTIVE and the registered previous h_count!=H_ACTIVE. Edge detection tolerates h_count being held for several clocks.
- Target line: tgt = v_count+1, or 0 when v_count==V_TOTAL-1. Latched at hb_start.
- FSM:
  - IDLE: on hb_start, latch tgt, clear the shadow slots and the hit counter, set idx=0, go to SCAN, busy=1.
  - SCAN: one descriptor per clock, idx 0..NUM_SPRITES-1.
    - Hit condition: en && y<=tgt && tgt<y+SPR_H. Compare at 11 bits so there is no wrap (y=1022 never hits line 0).
    - On a hit with count<SLOTS: write shadow slot[count] with {x, y, idx}, valid=1, and increment count.
    - On a hit with count==SLOTS: set overflow and leave the slots unchanged.
    - After idx=NUM_SPRITES-1, go to COMMIT.
  - COMMIT: copy all shadow slots to the active outputs in one cycle, busy=0, go to IDLE. Scan latency is NUM_SPRITES+2 clocks from hb_start, which is well inside blanking.
- hb_start while not IDLE is ignored; it cannot occur with legal timing.
- A descriptor write during SCAN is seen on this line only if its index has not yet been scanned. The same-cycle write/read of the same index uses the old value.
- Active slots change only in COMMIT. They are stable for the whole active line.
- Arbitration: registered, 1-clock latency.
  - pix_valid <= |(slot_visible & slot_valid).
  - pix_slot <= lowest k with slot_visible[k]&&slot_valid[k], else 0.
  - Lower slot index means lower descriptor index, which is the higher priority.
- overflow: sticky. Cleared by ovf_clr or reset. If a set and a clear happen in the same cycle, the set wins.
- Reset mid-scan: everything returns to reset values immediately. The next hb_start starts a clean scan.

Test Plan:
- Reset during SCAN (busy=1) -> busy, slot_valid, overflow, pix_valid all 0 at once; the next line's scan completes normally.
- Descriptors 2 {x=100,y=50,en=1} and 5 {x=300,y=52,en=1}, v_count=51, hb_start -> after 10 clocks:
  - slot0={100,50,id2}, slot1={300,52,id5}, slot_valid=0011, busy was high for 9 clocks.
- Six enabled sprites all with y=10, v_count=9 -> slots hold ids 0..3 in order, slot_valid=1111, overflow=1. Then ovf_clr pulse -> overflow=0.
- Boundaries with sprite y=20:
  - target lines 20 and 23 -> hit;
  - target lines 19 and 24 -> miss;
  - v_count=V_TOTAL-1 with y=0 -> hit (target 0);
  - y=1022, target 0 -> miss.
- slot_valid=0111, slot_visible=0110 -> next clock pix_valid=1, pix_slot=1. slot_visible=1000 (slot3 invalid) -> pix_valid=0.
- h_count held at 640 for 3 clocks -> exactly one scan. Write en=0 to idx 6 at scan cycle 3 -> sprite 6 is excluded; the same write at scan cycle 8 -> sprite 6 is still included this line.
